// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter with a TX FIFO and a programmable bit divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_write,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_hit,
  output logic        o_tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
`ifdef UART_TX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e          r_state;
  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic            r_ovf;
  logic [15:0]     r_div;
  logic [15:0]     r_bit_div;
  logic [15:0]     r_timer;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_tx;
`ifdef UART_TX_PARITY_EN
  logic            r_par;
`endif

  logic [1:0]      w_sel;
  logic            w_wr;
  logic [PW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_sel    = i_adr[3:2];
  assign o_hit    = (i_adr[31:4] == BASE_ADDR[31:4]) && (w_sel != 2'b11);
  assign w_wr     = i_mem_write && o_hit;
  assign w_count  = r_wptr - r_rptr;
  assign w_full   = (w_count == PW'(FIFO_DEPTH));
  assign w_empty  = (w_count == '0);
  // A push into a full FIFO is dropped even when the FSM pops in the same cycle.
  assign w_push   = w_wr && (w_sel == 2'd0) && !w_full;
  assign w_drop   = w_wr && (w_sel == 2'd0) && w_full;
  assign w_pop    = (r_state == StIdle) && !w_empty;
  assign w_status = {23'b0, 5'(w_count), r_ovf, w_empty, w_full, (r_state != StIdle)};
  assign w_unused = ^{i_adr[1:0], i_write_data[31:16]};
  assign o_tx     = r_tx;

  always_comb begin
    o_read_data = 32'b0;
    if (o_hit) begin
      case (w_sel)
        2'd1:    o_read_data = w_status;
        2'd2:    o_read_data = {16'b0, r_div};
        default: o_read_data = 32'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wptr[AW-1:0]] <= i_write_data[7:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ovf     <= 1'b0;
      r_div     <= DEFAULT_DIV;
      r_bit_div <= DEFAULT_DIV;
      r_timer   <= 16'd0;
      r_shift   <= 8'd0;
      r_bit_cnt <= 3'd0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_wr && (w_sel == 2'd1)) r_ovf <= 1'b0;
      else if (w_drop)             r_ovf <= 1'b1;
      if (w_wr && (w_sel == 2'd2)) begin
        r_div <= (i_write_data[15:0] == 16'd0) ? 16'd1 : i_write_data[15:0];
      end

      case (r_state)
        StIdle: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= r_fifo[r_rptr[AW-1:0]];
`ifdef UART_TX_PARITY_EN
            r_par     <= ^r_fifo[r_rptr[AW-1:0]];
`endif
            r_bit_div <= r_div;
            r_timer   <= r_div - 16'd1;
            r_tx      <= 1'b0;
            r_state   <= StStart;
          end
        end
        StStart: begin
          if (r_timer != 16'd0) r_timer <= r_timer - 16'd1;
          else begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_cnt <= 3'd0;
            r_timer   <= r_bit_div - 16'd1;
            r_state   <= StData;
          end
        end
        StData: begin
          if (r_timer != 16'd0) r_timer <= r_timer - 16'd1;
          else begin
            r_timer <= r_bit_div - 16'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_par;
              r_state <= StParity;
`else
              r_tx    <= 1'b1;
              r_state <= StStop;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (r_timer != 16'd0) r_timer <= r_timer - 16'd1;
          else begin
            r_tx    <= 1'b1;
            r_timer <= r_bit_div - 16'd1;
            r_state <= StStop;
          end
        end
`endif
        StStop: begin
          if (r_timer != 16'd0) r_timer <= r_timer - 16'd1;
          else r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed register checks plus random bytes and
// divisors compared against a frame-level serial model.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] s_data [8];
  int         s_div  [8];

  uart_tx_mmio #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(16'd868)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_mem_write (mem_write),
    .i_adr       (adr),
    .i_write_data(wdata),
    .o_read_data (rdata),
    .o_hit       (hit),
    .o_tx        (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial frame as the line should carry it, index 0 first.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write = 1'b1;
    adr       = a;
    wdata     = d;
    @(posedge clk);
    #1 mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    adr = a;
    #1;
    d = rdata;
    h = hit;
  endtask

  // Expects the first start bit on the edge after the caller's current cycle.
  task automatic check_stream(input int n, input bit busy_chk, input string tag);
    logic [10:0] fb;
    for (int f = 0; f < n; f++) begin
      fb = frame_bits(s_data[f]);
      for (int k = 0; k < NB; k++) begin
        for (int c = 0; c < s_div[f]; c++) begin
          @(posedge clk);
          #1 chk(tag, {31'b0, tx}, {31'b0, fb[k]});
          if (busy_chk) begin
            adr = BASE + 32'h4;
            #1 chk({tag, "_busy"}, {31'b0, rdata[0]}, 32'd1);
          end
        end
      end
      if (f < n - 1) begin
        @(posedge clk);
        #1 chk({tag, "_gap"}, {31'b0, tx}, 32'd1);
      end
    end
  endtask

  task automatic frame_end(input string tag);
    logic [31:0] d;
    logic        h;
    @(posedge clk);
    #1 chk({tag, "_idle_tx"}, {31'b0, tx}, 32'd1);
    rd(BASE + 32'h4, d, h);
    chk({tag, "_idle_status"}, d, 32'h4);
  endtask

  initial begin
    logic [31:0] d;
    logic        h;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          dv;
    int          cnt;
    int          pre;
    bit          ov;
    logic [31:0] exp_st;

    reset = 1'b0; mem_write = 1'b0; adr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 chk("rst_tx", {31'b0, tx}, 32'd1);
    rd(BASE + 32'h4, d, h);
    chk("rst_status_in_reset", d, 32'h4);
    chk("rst_hit_in_reset", {31'b0, h}, 32'd1);
    @(negedge clk) reset = 1'b1;

    rd(BASE + 32'h8, d, h);  chk("rst_baud", d, 32'h364);
    rd(BASE + 32'hC, d, h);  chk("hole_hit", {31'b0, h}, 32'd0);
    chk("hole_data", d, 32'd0);
    rd(BASE, d, h);          chk("txdata_read", d, 32'd0);
    chk("txdata_hit", {31'b0, h}, 32'd1);
    rd(BASE + 32'h6, d, h);  chk("low_bits_ignored", d, 32'h4);
    rd(32'h0000_2004, d, h); chk("other_base_hit", {31'b0, h}, 32'd0);
    chk("other_base_data", d, 32'd0);

    // Single 0xA5 frame at DIV=4 with busy sampled every cycle.
    wr(BASE + 32'h8, 32'd4);
    rd(BASE + 32'h8, d, h);  chk("baud4", d, 32'd4);
    wr(BASE, 32'hA5);
    s_data[0] = 8'hA5; s_div[0] = 4;
    check_stream(1, 1'b1, "a5");
    frame_end("a5");

    for (int r = 0; r < 3; r++) begin
      dv = int'($urandom_range(1, 5));
      b0 = 8'($urandom);
      wr(BASE + 32'h8, 32'(dv));
      wr(BASE, {24'($urandom), b0});
      s_data[0] = b0; s_div[0] = dv;
      check_stream(1, 1'b1, "rand");
      frame_end("rand");
    end

    // Six back-to-back pushes at DIV=2; the FSM pops one entry on the second write edge.
    cnt = 0; ov = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pre = cnt;
      if (k == 1) cnt--;
      if (pre >= DEPTH) ov = 1'b1;
      else begin
        cnt++;
        s_data[k] = 8'(k + 1);
        s_div[k]  = 2;
      end
    end
    exp_st = 32'h1 | (32'(cnt == DEPTH) << 1) | (32'(ov) << 3) | (32'(cnt) << 4);
    wr(BASE + 32'h8, 32'd2);
    wr(BASE, 32'd1);
    fork
      begin
        for (int k = 2; k <= 6; k++) wr(BASE, 32'(k));
        rd(BASE + 32'h4, d, h);
        chk("ovf_status", d, exp_st);
        wr(BASE + 32'h4, $urandom);
        rd(BASE + 32'h4, d, h);
        chk("ovf_cleared", d, exp_st & ~32'h8);
      end
      check_stream(DEPTH + 1, 1'b0, "ovf_stream");
    join
    frame_end("ovf");

    // Divider change mid-frame only affects the following frame.
    b0 = 8'($urandom); b1 = 8'($urandom);
    wr(BASE + 32'h8, 32'd2);
    wr(BASE, {24'b0, b0});
    s_data[0] = b0; s_div[0] = 2;
    s_data[1] = b1; s_div[1] = 8;
    fork
      begin
        wr(BASE, {24'b0, b1});
        repeat (8) @(posedge clk);
        wr(BASE + 32'h8, 32'd8);
      end
      check_stream(2, 1'b0, "baudchg");
    join
    frame_end("baudchg");
    rd(BASE + 32'h8, d, h);  chk("baud8", d, 32'd8);

    wr(BASE + 32'h8, 32'hABCD_0003);
    rd(BASE + 32'h8, d, h);  chk("baud_upper", d, 32'd3);
    wr(BASE + 32'h8, 32'h0);
    rd(BASE + 32'h8, d, h);  chk("baud0_reads1", d, 32'd1);
    b0 = 8'($urandom);
    wr(BASE, {24'b0, b0});
    s_data[0] = b0; s_div[0] = 1;
    check_stream(1, 1'b1, "div1");
    frame_end("div1");

    // Reset mid-DATA with two bytes still queued.
    wr(BASE + 32'h8, 32'd4);
    for (int k = 0; k < 3; k++) wr(BASE, $urandom);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    adr   = BASE + 32'h4;
    #1 chk("rst_mid_hit", {31'b0, hit}, 32'd1);
    @(posedge clk);
    #1 chk("rst_mid_tx", {31'b0, tx}, 32'd1);
    chk("rst_mid_status", rdata, 32'h4);
    @(negedge clk) reset = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1 chk("rst_no_frames", {31'b0, tx}, 32'd1);
    end
    rd(BASE + 32'h4, d, h);  chk("rst_after_status", d, 32'h4);
    rd(BASE + 32'h8, d, h);  chk("rst_after_baud", d, 32'h364);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
